// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e  : FSM state encoding (ST_IDLE / ST_SHIFT)
//   cnt_w()  : bit-counter width for a given operand width
package serial_subtractor_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ceiling log2, floored at 1 so a counter always has at least one bit.
  function automatic int cnt_w(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: Diff = A - B - Bin, with borrow out.
//   A, B  : operand bits
//   Bin   : borrow in
//   Diff  : difference bit
//   Bout  : borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first: Diff = A - B.
// One borrow cell is reused over WIDTH clock cycles per operation.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request an operation (honoured only when idle)
//   A, B  : minuend / subtrahend, captured on the accepting edge
//   busy  : operation in progress
//   done  : one-cycle pulse when Diff/Bout update
//   Diff  : (A - B) mod 2^WIDTH, held until next completion
//   Bout  : final unsigned borrow (A < B), held with Diff
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold last result
// ST_SHIFT | one operand bit pair processed per clock, LSB first
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fs_diff;
  logic fs_bout;

  full_subtractor u_fs (
    .A    (sa_q[0]),
    .B    (sb_q[0]),
    .Bin  (borrow_q),
    .Diff (fs_diff),
    .Bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d     = A;
          sb_d     = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
        res_d    = {fs_diff, res_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          diff_d  = {fs_diff, res_q[WIDTH-1:1]};
          bout_d  = fs_bout;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] Diff;
  logic       Bout;

  int checks   = 0;
  int failures = 0;
  int cycle_cnt = 0;
  int last_done_cycle = 0;
  int prev_done_cycle = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the operation is accepted on the following posedge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [7:0] ed, input logic eb,
                           input bit poke, input bit hold, input logic [7:0] hd,
                           input logic hb, input bit post);
    int cyc  = 0;
    int bcnt = 0;
    bit got  = 0;
    bit hold_bad = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) begin start = 1'b1; A = 8'd1;  B = 8'd1;  end
      if (poke && cyc == 4) begin start = 1'b0; A = 8'hAA; B = 8'h55; end
      if (done) begin
        got = 1;
        prev_done_cycle = last_done_cycle;
        last_done_cycle = cycle_cnt;
      end else begin
        if (busy) bcnt++;
        if (hold && (Diff !== hd || Bout !== hb)) hold_bad = 1;
      end
    end
    check_val({tag, "_done_seen"}, 32'(got), 32'd1);
    check_val({tag, "_latency"}, 32'(cyc - 1), 32'd8);
    check_val({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
    check_val({tag, "_diff"}, 32'(Diff), 32'(ed));
    check_val({tag, "_bout"}, 32'(Bout), 32'(eb));
    if (hold) check_val({tag, "_hold_prev"}, 32'(hold_bad), 32'd0);
    if (post) begin
      @(negedge clk);
      check_val({tag, "_single_pulse"}, 32'(done), 32'd0);
      check_val({tag, "_idle_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_diff", 32'(Diff), 32'd0);
    check_val("rst_bout", 32'(Bout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(8'd100, 8'd37);  wait_done("basic",   8'd63,  1'b0, 0, 0, 8'd0, 1'b0, 1);
    launch(8'd37,  8'd100); wait_done("neg",     8'd193, 1'b1, 0, 0, 8'd0, 1'b0, 1);
    launch(8'd0,   8'd255); wait_done("neg_min", 8'd1,   1'b1, 0, 0, 8'd0, 1'b0, 1);
    launch(8'd255, 8'd255); wait_done("equal",   8'd0,   1'b0, 0, 0, 8'd0, 1'b0, 1);
    launch(8'd0,   8'd0);   wait_done("zeros",   8'd0,   1'b0, 0, 0, 8'd0, 1'b0, 1);

    launch(8'd200, 8'd50);  wait_done("busy_start", 8'd150, 1'b0, 1, 0, 8'd0, 1'b0, 1);
    repeat (3) begin
      @(negedge clk);
      check_val("busy_start_no_restart", 32'(busy), 32'd0);
    end

    launch(8'd10, 8'd3);    wait_done("b2b_1", 8'd7,   1'b0, 0, 0, 8'd0, 1'b0, 0);
    launch(8'd3,  8'd10);   wait_done("b2b_2", 8'd249, 1'b1, 0, 1, 8'd7, 1'b0, 1);
    check_val("b2b_gap", 32'(last_done_cycle - prev_done_cycle), 32'd9);

    launch(8'd90, 8'd20);
    repeat (4) @(negedge clk);
    rst = 1'b1; start = 1'b1; A = 8'd5; B = 8'd2;
    @(negedge clk);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    check_val("midrst_diff", 32'(Diff), 32'd0);
    check_val("midrst_bout", 32'(Bout), 32'd0);
    @(negedge clk);
    check_val("rst_wins_over_start", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("post_rst_no_done", 32'(done), 32'd0);
    launch(8'd5, 8'd2);     wait_done("after_rst", 8'd3, 1'b0, 0, 0, 8'd0, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
